// File: rtl/multi_port_comparator.sv
// rtl/multi_port_comparator.sv - programmable multi-entry byte-offset pattern matcher for the sniffer receive path
//
// Holds a table of NUM_PORTS patterns, each with an enable bit. It compares every
// table entry at every byte offset of a two-word sliding window, so a pattern that
// straddles two beats is still found. It keeps sticky per-entry hit flags until
// clear or rst.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   clear            synchronous packet-boundary flush (table is kept)
//   cfg_we/idx/port/en   table write port
//   data_valid, data_in  input stream beat (byte 0 = bits[7:0] earliest)
//   data_out, data_out_valid   stream delayed by two accepted beats
//   match, match_vec, match_idx, match_pulse   sticky hit report
module multi_port_comparator #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    localparam int IDXW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cfg_we,
    input  logic [IDXW-1:0]       cfg_idx,
    input  logic [PORT_WIDTH-1:0] cfg_port,
    input  logic                  cfg_en,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  match,
    output logic [NUM_PORTS-1:0]  match_vec,
    output logic [IDXW-1:0]       match_idx,
    output logic                  match_pulse
);

    // Number of byte offsets at which a full pattern fits inside the window.
    localparam int NUM_CAND = (2 * DATA_WIDTH - PORT_WIDTH) / 8 + 1;

    logic [DATA_WIDTH-1:0]   stage0;
    logic [DATA_WIDTH-1:0]   stage1;
    logic [1:0]              fill;
    logic [PORT_WIDTH-1:0]   pat_tbl [NUM_PORTS];
    logic [NUM_PORTS-1:0]    en_tbl;
    logic [2*DATA_WIDTH-1:0] window;
    logic [NUM_PORTS-1:0]    hit;
    logic                    cfg_in_range;

    // The older word sits in the low half, so window byte order follows wire order.
    assign window       = {stage0, stage1};
    assign cfg_in_range = ({{(32-IDXW){1'b0}}, cfg_idx} < 32'(NUM_PORTS));
    assign match        = |match_vec;

    // A hit is possible only once the window holds two real beats.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int k = 0; k < NUM_CAND; k++) begin
                if (en_tbl[i] && (fill == 2'd2) &&
                    (window[8*k +: PORT_WIDTH] == pat_tbl[i])) begin
                    hit[i] = 1'b1;
                end
            end
        end
    end

    // The loop runs from high to low, so the lowest set flag is the last one written.
    always_comb begin
        match_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_idx = IDXW'(i);
            end
        end
    end

    // The table is independent of clear. A write lands at the edge, so the
    // comparison in the same cycle still sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pat_tbl[i] <= '0;
            end
            en_tbl <= '0;
        end else if (cfg_we && cfg_in_range) begin
            pat_tbl[cfg_idx] <= cfg_port;
            en_tbl[cfg_idx]  <= cfg_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage0         <= '0;
            stage1         <= '0;
            fill           <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            match_vec      <= '0;
            match_pulse    <= 1'b0;
        end else if (clear) begin
            // Flush wins over a simultaneous beat; that beat is dropped.
            stage0         <= '0;
            stage1         <= '0;
            fill           <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            match_vec      <= '0;
            match_pulse    <= 1'b0;
        end else begin
            match_vec   <= match_vec | hit;
            match_pulse <= (match_vec == '0) && (hit != '0);
            if (data_valid) begin
                stage0         <= data_in;
                stage1         <= stage0;
                data_out       <= stage1;
                data_out_valid <= (fill == 2'd2);
                if (fill != 2'd2) begin
                    fill <= fill + 2'd1;
                end
            end else begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_port_comparator.sv
// tb/tb_multi_port_comparator.sv - directed and randomized bench for multi_port_comparator
module tb_multi_port_comparator;

    localparam int DW = 32;
    localparam int PW = 16;
    localparam int NP = 4;
    localparam int IW = 2;
    localparam int DB = DW / 8;
    localparam int PB = PW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [PW-1:0] cfg_port;
    logic          cfg_en;
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          match;
    logic [NP-1:0] match_vec;
    logic [IW-1:0] match_idx;
    logic          match_pulse;

    multi_port_comparator #(.DATA_WIDTH(DW), .PORT_WIDTH(PW), .NUM_PORTS(NP)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_en(cfg_en),
        .data_valid(data_valid), .data_in(data_in),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .match(match), .match_vec(match_vec), .match_idx(match_idx),
        .match_pulse(match_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int miscompares = 0;

    // Reference model state: accepted words since the last flush, the table,
    // and the expected registered outputs.
    logic [DW-1:0] hist[$];
    logic [PW-1:0] m_pat [NP];
    logic          m_en  [NP];
    logic [NP-1:0] exp_vec;
    logic          exp_pulse;
    logic          exp_dov;
    logic [DW-1:0] exp_do;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NP; i++) begin
            m_pat[i] = '0;
            m_en[i]  = 1'b0;
        end
        exp_vec   = '0;
        exp_pulse = 1'b0;
        exp_dov   = 1'b0;
        exp_do    = '0;
    endtask

    // Byte-level search of the last two accepted words for each enabled entry.
    function automatic logic [NP-1:0] model_hit();
        logic [NP-1:0] h;
        logic [7:0]    b [2*DB];
        logic [DW-1:0] older;
        logic [DW-1:0] newer;
        logic [PW-1:0] p;
        bit            eq;
        h = '0;
        if (hist.size() < 2) return h;
        older = hist[hist.size()-2];
        newer = hist[hist.size()-1];
        for (int j = 0; j < DB; j++) begin
            b[j]      = 8'(older >> (8*j));
            b[DB + j] = 8'(newer >> (8*j));
        end
        for (int i = 0; i < NP; i++) begin
            if (!m_en[i]) continue;
            p = m_pat[i];
            for (int k = 0; k <= 2*DB - PB; k++) begin
                eq = 1'b1;
                for (int m = 0; m < PB; m++) begin
                    if (b[k+m] != 8'(p >> (8*m))) eq = 1'b0;
                end
                if (eq) h[i] = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic [IW-1:0] lowest(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) begin
            if (v[i]) return IW'(i);
        end
        return '0;
    endfunction

    task automatic check_all();
        chk("data_out_valid", 64'(data_out_valid), 64'(exp_dov));
        chk("data_out",       64'(data_out),       64'(exp_do));
        chk("match_vec",      64'(match_vec),      64'(exp_vec));
        chk("match",          64'(match),          64'(exp_vec != '0));
        chk("match_idx",      64'(match_idx),      64'(lowest(exp_vec)));
        chk("match_pulse",    64'(match_pulse),    64'(exp_pulse));
    endtask

    // One clock cycle: drive inputs, advance the model, then sample after the edge.
    task automatic step(input logic dv, input logic [DW-1:0] din, input logic clr,
                        input logic we, input int idx, input logic [PW-1:0] port,
                        input logic en);
        logic [NP-1:0] h;
        data_valid = dv;
        data_in    = din;
        clear      = clr;
        cfg_we     = we;
        cfg_idx    = IW'(idx);
        cfg_port   = port;
        cfg_en     = en;
        h = model_hit();
        if (clr) begin
            exp_vec   = '0;
            exp_pulse = 1'b0;
            exp_dov   = 1'b0;
            exp_do    = '0;
            hist.delete();
        end else begin
            exp_pulse = (exp_vec == '0) && (h != '0);
            exp_vec   = exp_vec | h;
            if (dv) begin
                exp_dov = (hist.size() >= 2);
                exp_do  = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
                hist.push_back(din);
                if (hist.size() > 2) void'(hist.pop_front());
            end else begin
                exp_dov = 1'b0;
            end
        end
        if (we && idx < NP) begin
            m_pat[idx] = port;
            m_en[idx]  = en;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic beat(input logic [DW-1:0] w);
        step(1'b1, w, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic prog(input int idx, input logic [PW-1:0] port, input logic en);
        step(1'b0, '0, 1'b0, 1'b1, idx, port, en);
    endtask

    task automatic flush();
        step(1'b0, '0, 1'b1, 1'b0, 0, '0, 1'b0);
    endtask

    function automatic logic [7:0] rb();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'h50;
            2:       return 8'h12;
            default: return 8'h34;
        endcase
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_port = '0;
        cfg_en = 1'b0; data_valid = 1'b0; data_in = '0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Aligned hit at offset 6.
        prog(0, 16'h0050, 1'b1);
        beat(32'h1122_3344);
        beat(32'h0050_1234);
        chk("aligned_pre", 64'(match_vec), 64'(4'b0000));
        idle();
        chk("aligned_vec",   64'(match_vec),   64'(4'b0001));
        chk("aligned_pulse", 64'(match_pulse), 64'(1'b1));
        idle();
        chk("aligned_pulse_off", 64'(match_pulse), 64'(1'b0));

        // Straddle across the word boundary.
        flush();
        prog(2, 16'hCDAB, 1'b1);
        beat(32'hAB00_0000);
        beat(32'h0000_00CD);
        idle();
        chk("straddle_vec", 64'(match_vec), 64'(4'b0100));
        chk("straddle_idx", 64'(match_idx), 64'(2));

        // Disabled entry and lowest-index report.
        flush();
        prog(1, 16'h1234, 1'b0);
        prog(3, 16'h1234, 1'b1);
        prog(2, 16'h3344, 1'b1);
        beat(32'h1122_3344);
        beat(32'h0000_1234);
        idle();
        chk("lowest_vec", 64'(match_vec), 64'(4'b1100));
        chk("lowest_idx", 64'(match_idx), 64'(2));
        idle();

        // Clear together with a beat drops the beat and keeps the table.
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, '0, 1'b0);
        chk("clear_vec", 64'(match_vec), 64'(0));
        beat(32'h1122_3344);
        beat(32'h0000_1234);
        idle();
        chk("replay_vec", 64'(match_vec), 64'(4'b1100));

        // Stalls between beats.
        flush();
        beat(32'hA1A1_A1A1);
        idle(); idle(); idle();
        beat(32'hB2B2_B2B2);
        beat(32'hC3C3_C3C3);
        chk("stall_dov", 64'(data_out_valid), 64'(1'b1));
        chk("stall_do",  64'(data_out),       64'(32'hA1A1_A1A1));

        // Clear and table write in the same cycle.
        step(1'b0, '0, 1'b1, 1'b1, 1, 16'h5050, 1'b1);
        beat(32'h5050_0000);
        beat(32'h0000_0000);
        idle();

        // Asynchronous reset between edges, mid-packet.
        flush();
        prog(0, 16'h0050, 1'b1);
        beat(32'h1122_3344);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        beat(32'h1122_3344);
        beat(32'h0050_1234);
        idle();
        chk("post_reset_vec", 64'(match_vec), 64'(0));

        // Randomized traffic over a small byte alphabet so hits are frequent.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                flush();
            end else if (r < 9) begin
                step(1'(($urandom_range(0, 1))), {rb(), rb(), rb(), rb()}, 1'b1,
                     1'b1, $urandom_range(0, NP-1), {rb(), rb()}, 1'(($urandom_range(0, 1))));
            end else if (r < 20) begin
                step(1'(($urandom_range(0, 1))), {rb(), rb(), rb(), rb()}, 1'b0,
                     1'b1, $urandom_range(0, NP-1), {rb(), rb()}, 1'(($urandom_range(0, 3) != 0)));
            end else if (r < 75) begin
                beat({rb(), rb(), rb(), rb()});
            end else begin
                idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
